cpu_wrapper_v3: RTL and testbench

CPU_WRAPPER_V3 -- requirements
Module: cpu_wrapper_v3

---
 rtl/cpu_v3_pkg.sv | 56 +++++
 rtl/cpu_wrapper_v3_mem.sv | 27 ++
 rtl/cpu_wrapper_v3_pc.sv | 21 ++
 rtl/cpu_wrapper_v3_regfile.sv | 27 ++
 rtl/cpu_wrapper_v3.sv | 154 +++++++++++++++
 tb/tb_cpu_wrapper_v3.sv | 330 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_v3_pkg.sv
// Shared constants, writeback record and ALU helper for the 8-bit cpu_wrapper_v3 core.
package cpu_v3_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;

  localparam logic [ADDR_W-1:0] INT_VECTOR = 8'hF0;
  localparam logic [DATA_W-1:0] INSTR_NOP  = 8'h00;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_IO  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_RTI = 4'hB;
  localparam logic [3:0] OP_IMM = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_STI = 4'hE;

  localparam logic [1:0] IO_OUT  = 2'd0;
  localparam logic [1:0] IO_IN   = 2'd1;
  localparam logic [1:0] IMM_LDM = 2'd0;
  localparam logic [1:0] IMM_LDD = 2'd1;
  localparam logic [1:0] IMM_STD = 2'd2;

  typedef struct packed {
    logic              reg_we;
    logic [REG_AW-1:0] rd;
    logic              out_we;
    logic [DATA_W-1:0] data;
  } wb_t;

  localparam wb_t WB_BUBBLE = '0;

  function automatic logic is_two_byte(input logic [3:0] op);
    return op == OP_IMM;
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/cpu_wrapper_v3_mem.sv
// 256-byte unified memory: fetch port returns instruction and following byte, plus a data port.
module cpu_wrapper_v3_mem
  import cpu_v3_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [DATA_W-1:0] fetch_imm,
  input  logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] imm_addr;

  // Contents are deliberately not reset; programs are preloaded from outside.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign imm_addr    = fetch_addr + 8'd1;
  assign fetch_instr = mem[fetch_addr];
  assign fetch_imm   = mem[imm_addr];
  assign data_rdata  = mem[data_addr];
endmodule

// File: rtl/cpu_wrapper_v3_pc.sv
// Program counter: redirect has priority, otherwise step past a one- or two-byte instruction.
module cpu_wrapper_v3_pc
  import cpu_v3_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  input  logic              two_byte,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_current;

  always_ff @(posedge clk) begin
    if (srst)          pc_current <= '0;
    else if (redirect) pc_current <= target;
    else               pc_current <= pc_current + (two_byte ? 8'd2 : 8'd1);
  end

  assign pc = pc_current;
endmodule

// File: rtl/cpu_wrapper_v3_regfile.sv
// Four-entry register file: two combinational read ports, one write port.
module cpu_wrapper_v3_regfile
  import cpu_v3_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/cpu_wrapper_v3.sv
// Three-stage (IF/EX/WB) 8-bit CPU with WB->EX forwarding and a single-level interrupt.
module cpu_wrapper_v3
  import cpu_v3_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] I_Port,
  input  logic              int_sig,
  output logic [DATA_W-1:0] O_Port
);
  logic [ADDR_W-1:0] pc_current;
  logic [DATA_W-1:0] fetch_instr, fetch_imm;
  logic [DATA_W-1:0] IR, imm_reg;
  logic [3:0]        op;
  logic [REG_AW-1:0] ra, rb;
  logic [DATA_W-1:0] rdata_a, rdata_b, opnd_a, opnd_b;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  wb_t               wb_reg, wb_next;
  logic              z_reg, z_next;
  logic              in_service_reg;
  logic [ADDR_W-1:0] epc_reg;
  logic              taken, rti, store;
  logic [ADDR_W-1:0] target;
  logic              irq_take, redirect, two_byte;
  logic [ADDR_W-1:0] redirect_pc;

  assign op = IR[7:4];
  assign ra = IR[3:2];
  assign rb = IR[1:0];

  // The only in-flight producer not yet in the register file is the WB stage.
  assign opnd_a   = (wb_reg.reg_we && wb_reg.rd == ra) ? wb_reg.data : rdata_a;
  assign opnd_b   = (wb_reg.reg_we && wb_reg.rd == rb) ? wb_reg.data : rdata_b;
  assign mem_addr = (op == OP_LDI || op == OP_STI) ? opnd_a : imm_reg;

  always_comb begin
    wb_next = WB_BUBBLE;
    z_next  = z_reg;
    taken   = 1'b0;
    rti     = 1'b0;
    store   = 1'b0;
    target  = opnd_b;
    case (op)
      OP_MOV: begin
        wb_next.reg_we = 1'b1;
        wb_next.rd     = ra;
        wb_next.data   = opnd_b;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        wb_next.reg_we = 1'b1;
        wb_next.rd     = ra;
        wb_next.data   = alu(op, opnd_a, opnd_b);
        z_next         = (wb_next.data == '0);
      end
      OP_IO: begin
        if (ra == IO_OUT) begin
          wb_next.out_we = 1'b1;
          wb_next.data   = opnd_b;
        end else if (ra == IO_IN) begin
          wb_next.reg_we = 1'b1;
          wb_next.rd     = rb;
          wb_next.data   = I_Port;
        end
      end
      OP_JMP: taken = 1'b1;
      OP_JZ:  taken = z_reg;
      OP_RTI: begin
        taken  = 1'b1;
        rti    = 1'b1;
        target = epc_reg;
      end
      OP_IMM: begin
        if (ra == IMM_LDM || ra == IMM_LDD) begin
          wb_next.reg_we = 1'b1;
          wb_next.rd     = rb;
          wb_next.data   = (ra == IMM_LDM) ? imm_reg : mem_rdata;
        end else if (ra == IMM_STD) begin
          store = 1'b1;
        end
      end
      OP_LDI: begin
        wb_next.reg_we = 1'b1;
        wb_next.rd     = rb;
        wb_next.data   = mem_rdata;
      end
      OP_STI:  store = 1'b1;
      default: ;
    endcase
  end

  assign irq_take    = int_sig && !in_service_reg;
  assign redirect    = taken || irq_take;
  assign redirect_pc = irq_take ? INT_VECTOR : target;
  assign two_byte    = is_two_byte(fetch_instr[7:4]);

  cpu_wrapper_v3_pc PC (
    .clk      (clk),
    .srst     (rstn),
    .redirect (redirect),
    .target   (redirect_pc),
    .two_byte (two_byte),
    .pc       (pc_current)
  );

  cpu_wrapper_v3_mem mem_inst (
    .clk         (clk),
    .we          (store && !rstn),
    .waddr       (mem_addr),
    .wdata       (opnd_b),
    .fetch_addr  (pc_current),
    .fetch_instr (fetch_instr),
    .fetch_imm   (fetch_imm),
    .data_addr   (mem_addr),
    .data_rdata  (mem_rdata)
  );

  cpu_wrapper_v3_regfile regfile_inst (
    .clk     (clk),
    .srst    (rstn),
    .we      (wb_reg.reg_we),
    .waddr   (wb_reg.rd),
    .wdata   (wb_reg.data),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      IR             <= INSTR_NOP;
      imm_reg        <= '0;
      wb_reg         <= WB_BUBBLE;
      z_reg          <= 1'b0;
      in_service_reg <= 1'b0;
      epc_reg        <= '0;
      O_Port         <= '0;
    end else begin
      IR      <= redirect ? INSTR_NOP : fetch_instr;
      imm_reg <= redirect ? '0 : fetch_imm;
      wb_reg  <= wb_next;
      z_reg   <= z_next;
      // EPC is the first instruction not yet executed: the discarded fetch, or a branch target.
      if (irq_take) begin
        in_service_reg <= 1'b1;
        epc_reg        <= taken ? target : pc_current;
      end else if (rti) begin
        in_service_reg <= 1'b0;
      end
      if (wb_reg.out_we) O_Port <= wb_reg.data;
    end
  end
endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Scoreboard bench for cpu_wrapper_v3: ISA-level reference model plus directed and random programs.
module tb_cpu_wrapper_v3;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       int_sig = 1'b0;
  logic [7:0] I_Port = 8'h00;
  logic [7:0] O_Port;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] prog [0:255];
  logic [7:0] m_mem [0:255];
  logic [7:0] m_reg [0:3];
  logic       m_z;
  int         gen_addr;
  logic [7:0] stop_pc;

  always #5 clk = ~clk;

  cpu_wrapper_v3 dut (
    .clk     (clk),
    .rstn    (rstn),
    .I_Port  (I_Port),
    .int_sig (int_sig),
    .O_Port  (O_Port)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: every OUT reaching writeback must match the next expected port value.
  always @(posedge clk) begin
    if (!rstn && dut.wb_reg.out_we) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %02h expected no write", O_Port);
      end else begin
        mon_exp = exp_q.pop_front();
        check8("out_port", O_Port, mon_exp);
        $display("OUT write %02h (expected %02h)", O_Port, mon_exp);
      end
    end
  end

  // Instruction-set model: executes the program one instruction at a time until stop.
  task automatic model_run(input logic [7:0] stop, input logic [7:0] iport);
    logic [7:0] pc, ins, imm, ia, nxt;
    logic [3:0] op;
    logic [1:0] ra, rb;
    for (int i = 0; i < 256; i++) m_mem[i] = prog[i];
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_z = 1'b0;
    pc = 8'h00;
    for (int step = 0; step < 2000 && pc != stop; step++) begin
      ins = m_mem[pc];
      ia  = pc + 8'd1;
      imm = m_mem[ia];
      op  = ins[7:4];
      ra  = ins[3:2];
      rb  = ins[1:0];
      nxt = pc + ((op == 4'hC) ? 8'd2 : 8'd1);
      case (op)
        4'h1: m_reg[ra] = m_reg[rb];
        4'h2: begin m_reg[ra] = m_reg[ra] + m_reg[rb]; m_z = (m_reg[ra] == 8'h00); end
        4'h3: begin m_reg[ra] = m_reg[ra] - m_reg[rb]; m_z = (m_reg[ra] == 8'h00); end
        4'h4: begin m_reg[ra] = m_reg[ra] & m_reg[rb]; m_z = (m_reg[ra] == 8'h00); end
        4'h5: begin m_reg[ra] = m_reg[ra] | m_reg[rb]; m_z = (m_reg[ra] == 8'h00); end
        4'h7: begin
          if (ra == 2'd0) exp_q.push_back(m_reg[rb]);
          else if (ra == 2'd1) m_reg[rb] = iport;
        end
        4'h8: nxt = m_reg[rb];
        4'h9: if (m_z) nxt = m_reg[rb];
        4'hC: begin
          if (ra == 2'd0) m_reg[rb] = imm;
          else if (ra == 2'd1) m_reg[rb] = m_mem[imm];
          else if (ra == 2'd2) m_mem[imm] = m_reg[rb];
        end
        4'hD: m_reg[rb] = m_mem[m_reg[ra]];
        4'hE: m_mem[m_reg[ra]] = m_reg[rb];
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    check8({tag, "_rst_pc"}, dut.PC.pc_current, 8'h00);
    check8({tag, "_rst_ir"}, dut.IR, 8'h00);
    check8({tag, "_rst_oport"}, O_Port, 8'h00);
    check8({tag, "_rst_z"}, {7'd0, dut.z_reg}, 8'h00);
    check8({tag, "_rst_insvc"}, {7'd0, dut.in_service_reg}, 8'h00);
    check8({tag, "_rst_epc"}, dut.epc_reg, 8'h00);
    for (int i = 0; i < 4; i++) check8($sformatf("%s_rst_r%0d", tag, i), dut.regfile_inst.regs[i], 8'h00);
  endtask

  // Holds reset for two edges, preloads memory, checks reset state; leaves reset asserted.
  task automatic load_and_reset(input string tag);
    rstn = 1'b1;
    int_sig = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = prog[i];
    @(negedge clk);
    check_reset_state(tag);
  endtask

  task automatic compare_state(input string tag);
    int bad;
    logic [7:0] first_act, first_exp;
    for (int i = 0; i < 4; i++) check8($sformatf("%s_r%0d", tag, i), dut.regfile_inst.regs[i], m_reg[i]);
    check8({tag, "_z"}, {7'd0, dut.z_reg}, {7'd0, m_z});
    bad = 0;
    first_act = 8'h00;
    first_exp = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (dut.mem_inst.mem[i] !== m_mem[i]) begin
        if (bad == 0) begin first_act = dut.mem_inst.mem[i]; first_exp = m_mem[i]; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_mem: %0d bytes differ, first got %02h expected %02h", tag, bad, first_act, first_exp);
    end
  endtask

  task automatic check_queue_empty(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_outs: got %0d writes pending expected 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic wait_pc(input logic [7:0] target, input int budget, input string name);
    int n = 0;
    while (dut.PC.pc_current !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check8(name, dut.PC.pc_current, target);
  endtask

  task automatic wait_ir(input logic [7:0] target, input int budget, input string name);
    int n = 0;
    while (dut.IR !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check8(name, dut.IR, target);
  endtask

  task automatic emit(input logic [7:0] b);
    prog[gen_addr] = b;
    gen_addr++;
  endtask

  // Straight-line random program; stores and pointers stay in 80h..EFh, away from code.
  task automatic gen_random(output logic [7:0] stop);
    logic [1:0] r1, r2;
    logic [7:0] ptr;
    for (int i = 0; i < 256; i++) prog[i] = (i >= 8'h80 && i < 8'hF0) ? 8'($urandom) : 8'h00;
    gen_addr = 0;
    repeat (24) begin
      r1  = 2'($urandom);
      r2  = 2'($urandom);
      ptr = 8'h80 + 8'($urandom_range(0, 8'h6F));
      case ($urandom_range(0, 11))
        0: emit({4'h1, r1, r2});
        1: emit({4'h2, r1, r2});
        2: emit({4'h3, r1, r2});
        3: emit({4'h4, r1, r2});
        4: emit({4'h5, r1, r2});
        5: emit({4'h7, 2'd0, r2});
        6: emit({4'h7, 2'd1, r2});
        7: begin emit({4'hC, 2'd0, r2}); emit(8'($urandom)); end
        8: begin emit({4'hC, 2'd1, r2}); emit(ptr); end
        9: begin emit({4'hC, 2'd2, r2}); emit(ptr); end
        10: begin
          emit({4'hC, 2'd0, r1});
          emit(ptr);
          emit({($urandom_range(0, 1) == 0) ? 4'hD : 4'hE, r1, r2});
        end
        default: begin
          case ($urandom_range(0, 4))
            0: emit(8'h00);
            1: emit({4'h6, r1, r2});
            2: emit({4'hA, r1, r2});
            3: emit({4'h7, 1'b1, r1[0], r2});
            default: begin emit({4'hC, 2'd3, r2}); emit(8'($urandom)); end
          endcase
        end
      endcase
    end
    stop = 8'(gen_addr + 2);
    emit({4'hC, 2'd0, 2'd3});
    emit(stop);
    emit({4'h8, 2'd0, 2'd3});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Store through a freshly loaded pointer.
    clear_prog();
    prog[0] = 8'hC0; prog[1] = 8'h64; prog[2] = 8'hC1;
    prog[3] = 8'h55; prog[4] = 8'hE1; prog[5] = 8'h00;
    load_and_reset("ldm_sti");
    rstn = 1'b0;
    repeat (10) @(negedge clk);
    check8("ldm_sti_r0", dut.regfile_inst.regs[0], 8'd100);
    check8("ldm_sti_r1", dut.regfile_inst.regs[1], 8'h55);
    check8("ldm_sti_mem100", dut.mem_inst.mem[100], 8'h55);
    $display("ldm_sti: R0=%02h R1=%02h mem[100]=%02h", dut.regfile_inst.regs[0],
             dut.regfile_inst.regs[1], dut.mem_inst.mem[100]);
    check_queue_empty("ldm_sti");

    // SUB sets Z, taken JZ squashes the following instruction.
    clear_prog();
    prog[0] = 8'hC1; prog[1] = 8'h05; prog[2] = 8'hC2; prog[3] = 8'h05;
    prog[4] = 8'hC3; prog[5] = 8'h20; prog[6] = 8'h36; prog[7] = 8'h93;
    prog[8] = 8'hC0; prog[9] = 8'h77; prog[8'h20] = 8'h83;
    model_run(8'h20, 8'h00);
    load_and_reset("jz");
    rstn = 1'b0;
    wait_pc(8'h20, 20, "jz_reach_20");
    repeat (10) @(negedge clk);
    check8("jz_r1_zero", dut.regfile_inst.regs[1], 8'h00);
    check8("jz_skipped_r0", dut.regfile_inst.regs[0], 8'h00);
    compare_state("jz");
    check_queue_empty("jz");
    $display("jz: R1=%02h Z=%0d PC=%02h", dut.regfile_inst.regs[1], dut.z_reg, dut.PC.pc_current);

    // IN then dependent OUT.
    clear_prog();
    prog[0] = 8'h76; prog[1] = 8'h72; prog[2] = 8'hC3; prog[3] = 8'h04; prog[4] = 8'h83;
    I_Port = 8'hA5;
    model_run(8'h04, I_Port);
    load_and_reset("io");
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    check8("io_latency", O_Port, 8'hA5);
    repeat (20) @(negedge clk);
    check8("io_hold", O_Port, 8'hA5);
    compare_state("io");
    check_queue_empty("io");

    // Interrupt entry, ignored nested request, RTI, then a second accepted interrupt.
    clear_prog();
    prog[0] = 8'hC3; prog[1] = 8'h10; prog[2] = 8'h83; prog[8'h14] = 8'h83;
    prog[8'hF0] = 8'hC1; prog[8'hF1] = 8'h5A; prog[8'hF2] = 8'h71; prog[8'hF5] = 8'hB0;
    load_and_reset("irq");
    rstn = 1'b0;
    wait_pc(8'h10, 20, "irq_loop_entry");
    exp_q.push_back(8'h5A);
    int_sig = 1'b1;
    @(negedge clk);
    int_sig = 1'b0;
    check8("irq_vector_pc", dut.PC.pc_current, 8'hF0);
    check8("irq_epc", dut.epc_reg, 8'h10);
    check8("irq_in_service", {7'd0, dut.in_service_reg}, 8'h01);
    @(negedge clk);
    int_sig = 1'b1;
    @(negedge clk);
    int_sig = 1'b0;
    wait_pc(8'h10, 30, "irq_rti_return");
    check8("irq_epc_kept", dut.epc_reg, 8'h10);
    check8("irq_cleared", {7'd0, dut.in_service_reg}, 8'h00);
    wait_pc(8'h12, 10, "irq_second_wait");
    exp_q.push_back(8'h5A);
    int_sig = 1'b1;
    @(negedge clk);
    int_sig = 1'b0;
    check8("irq2_vector_pc", dut.PC.pc_current, 8'hF0);
    check8("irq2_epc", dut.epc_reg, 8'h12);
    wait_pc(8'h12, 30, "irq2_rti_return");
    repeat (2) @(negedge clk);
    check8("irq_r1", dut.regfile_inst.regs[1], 8'h5A);
    check_queue_empty("irq");

    // Reset while a store is in EX and an OUT is in WB.
    clear_prog();
    prog[0] = 8'hC0; prog[1] = 8'h80; prog[2] = 8'hC1; prog[3] = 8'h33;
    prog[4] = 8'h71; prog[5] = 8'hE1; prog[6] = 8'hC3; prog[7] = 8'h08; prog[8] = 8'h83;
    load_and_reset("midrst");
    rstn = 1'b0;
    wait_ir(8'hE1, 20, "midrst_sti_in_ex");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    check8("midrst_mem80", dut.mem_inst.mem[8'h80], 8'h00);
    check_queue_empty("midrst");

    // Random straight-line programs against the model.
    for (int t = 0; t < 6; t++) begin
      I_Port = 8'($urandom);
      gen_random(stop_pc);
      model_run(stop_pc, I_Port);
      $display("random %0d: %0d bytes, %0d OUTs expected", t, gen_addr, exp_q.size());
      load_and_reset($sformatf("rnd%0d", t));
      rstn = 1'b0;
      repeat (150) @(negedge clk);
      compare_state($sformatf("rnd%0d", t));
      check_queue_empty($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
